duft_ap_chain_slave: RTL and testbench



---
 rtl/duft_ap_chain_slave.sv | 191 +++++++++++++++++++
 tb/tb_duft_ap_chain_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duft_ap_chain_slave.sv
// Responder end of the DUFT ap_ctrl_chain register-access protocol.
// Decodes single-word read/write transactions into control, status, DUT and DFT windows.
module duft_ap_chain_slave #(
   parameter int ACCESS_LAT = 1,
   parameter int N_DUT_IN   = 8,
   parameter int N_DUT_OUT  = 8,
   parameter int N_DFT_OUT  = 8
) (
   input  logic                     clk,
   input  logic                     ap_rst,
   input  logic [31:0]              addr,
   input  logic [31:0]              wr_data,
   input  logic                     rd_wr,
   input  logic                     ap_start,
   input  logic                     ap_continue,
   output logic                     ap_idle,
   output logic                     ap_ready,
   output logic                     ap_done,
   output logic [31:0]              ap_return,
   output logic [31:0]              op_code,
   output logic                     op_wr,
   output logic [31:0]              cfg,
   output logic [32*N_DUT_IN-1:0]   dut_in,
   input  logic [31:0]              status_in,
   input  logic [32*N_DUT_OUT-1:0]  dut_out,
   input  logic [32*N_DFT_OUT-1:0]  dft_out,
   output logic                     addr_err
);

   localparam int CW     = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
   localparam int DIN_W  = (N_DUT_IN  > 1) ? $clog2(N_DUT_IN)  : 1;
   localparam int DOUT_W = (N_DUT_OUT > 1) ? $clog2(N_DUT_OUT) : 1;
   localparam int DFT_W  = (N_DFT_OUT > 1) ? $clog2(N_DFT_OUT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_LAT - 1);

   localparam logic [31:0] A_OPCODE   = 32'h0000_0000;
   localparam logic [31:0] A_STATE    = 32'h0000_0001;
   localparam logic [31:0] A_CONFIG   = 32'h0000_0002;
   localparam logic [31:0] A_DUT_IN   = 32'h0000_0010;
   localparam logic [31:0] A_DUT_OUT  = 32'h0000_0018;
   localparam logic [31:0] A_DFT_OUT  = 32'h0000_0020;
   localparam logic [31:0] A_TEST_IN  = 32'hFF00_0000;
   localparam logic [31:0] A_TEST_OUT = 32'hFF00_0001;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t                      r_state;
   state_t                      w_nextState;
   logic [CW-1:0]               r_latCnt;
   logic [31:0]                 r_addr;
   logic [31:0]                 r_wrData;
   logic                        r_rdWr;
   logic [31:0]                 r_apReturn;
   logic [31:0]                 r_opCode;
   logic                        r_opWr;
   logic [31:0]                 r_cfg;
   logic [31:0]                 r_test;
   logic                        r_addrErr;
   logic [N_DUT_IN-1:0][31:0]   r_dutIn;
   logic [N_DUT_OUT-1:0][31:0]  w_dutOut;
   logic [N_DFT_OUT-1:0][31:0]  w_dftOut;
   logic                        w_lastExec;
   logic                        w_hitDutIn;
   logic                        w_hitDutOut;
   logic                        w_hitDftOut;
   logic [31:0]                 w_rdData;
   logic                        w_valid;
   logic                        w_ro;
   logic                        w_err;

   assign w_dutOut   = dut_out;
   assign w_dftOut   = dft_out;
   assign w_lastExec = (r_state == S_EXEC) && (r_latCnt == LAST_CNT);

   // Window bases are aligned to their maximum size, so the low address bits are the word index.
   assign w_hitDutIn  = (r_addr >= A_DUT_IN)  && (r_addr < A_DUT_IN  + 32'(N_DUT_IN));
   assign w_hitDutOut = (r_addr >= A_DUT_OUT) && (r_addr < A_DUT_OUT + 32'(N_DUT_OUT));
   assign w_hitDftOut = (r_addr >= A_DFT_OUT) && (r_addr < A_DFT_OUT + 32'(N_DFT_OUT));

   always_comb begin
      w_rdData = '0;
      w_valid  = 1'b0;
      w_ro     = 1'b0;
      if (r_addr == A_OPCODE) begin
         w_rdData = r_opCode;
         w_valid  = 1'b1;
      end else if (r_addr == A_STATE) begin
         w_rdData = status_in;
         w_valid  = 1'b1;
         w_ro     = 1'b1;
      end else if (r_addr == A_CONFIG) begin
         w_rdData = r_cfg;
         w_valid  = 1'b1;
      end else if (r_addr == A_TEST_IN) begin
         w_rdData = r_test;
         w_valid  = 1'b1;
      end else if (r_addr == A_TEST_OUT) begin
         w_rdData = r_test;
         w_valid  = 1'b1;
         w_ro     = 1'b1;
      end else if (w_hitDutIn) begin
         w_rdData = r_dutIn[r_addr[DIN_W-1:0]];
         w_valid  = 1'b1;
      end else if (w_hitDutOut) begin
         w_rdData = w_dutOut[r_addr[DOUT_W-1:0]];
         w_valid  = 1'b1;
         w_ro     = 1'b1;
      end else if (w_hitDftOut) begin
         w_rdData = w_dftOut[r_addr[DFT_W-1:0]];
         w_valid  = 1'b1;
         w_ro     = 1'b1;
      end
   end

   assign w_err = !w_valid || (!r_rdWr && w_ro);

   always_ff @(posedge clk) begin
      if (ap_rst) r_state <= S_IDLE;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      ap_idle     = 1'b0;
      ap_ready    = 1'b0;
      ap_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) w_nextState = S_EXEC;
         end
         S_EXEC: begin
            ap_ready = (r_latCnt == '0);
            if (w_lastExec) w_nextState = S_DONE;
         end
         S_DONE: begin
            ap_done = 1'b1;
            if (ap_continue) w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   // Abandoned transactions never commit because reset clears everything before w_lastExec is seen.
   always_ff @(posedge clk) begin
      if (ap_rst) begin
         r_latCnt   <= '0;
         r_addr     <= '0;
         r_wrData   <= '0;
         r_rdWr     <= 1'b0;
         r_apReturn <= '0;
         r_opCode   <= '0;
         r_opWr     <= 1'b0;
         r_cfg      <= '0;
         r_test     <= '0;
         r_addrErr  <= 1'b0;
         r_dutIn    <= '0;
      end else begin
         r_opWr    <= 1'b0;
         r_addrErr <= 1'b0;
         r_latCnt  <= (r_state == S_EXEC && !w_lastExec) ? r_latCnt + 1'b1 : '0;
         if (r_state == S_IDLE && ap_start) begin
            r_addr   <= addr;
            r_wrData <= wr_data;
            r_rdWr   <= rd_wr;
         end
         if (w_lastExec) begin
            r_addrErr <= w_err;
            if (r_rdWr) begin
               r_apReturn <= w_rdData;
            end else if (!w_err) begin
               if (r_addr == A_OPCODE) begin
                  r_opCode <= r_wrData;
                  r_opWr   <= 1'b1;
               end
               if (r_addr == A_CONFIG)  r_cfg  <= r_wrData;
               if (r_addr == A_TEST_IN) r_test <= r_wrData;
               if (w_hitDutIn)          r_dutIn[r_addr[DIN_W-1:0]] <= r_wrData;
            end
         end
      end
   end

   assign ap_return = r_apReturn;
   assign op_code   = r_opCode;
   assign op_wr     = r_opWr;
   assign cfg       = r_cfg;
   assign dut_in    = r_dutIn;
   assign addr_err  = r_addrErr;

endmodule

// File: tb/tb_duft_ap_chain_slave.sv
// Directed testbench for duft_ap_chain_slave: one instance at ACCESS_LAT=1,
// a second at ACCESS_LAT=4 for the reset-during-EXEC scenario.
module tb_duft_ap_chain_slave;

   logic          clk;
   logic          ap_rst, ap_rst2;
   logic [31:0]   addr, wr_data, addr2, wr_data2;
   logic          rd_wr, ap_start, ap_continue, rd_wr2, ap_start2, ap_continue2;
   logic          ap_idle, ap_ready, ap_done, ap_idle2, ap_ready2, ap_done2;
   logic [31:0]   ap_return, op_code, cfg, ap_return2, op_code2, cfg2;
   logic          op_wr, addr_err, op_wr2, addr_err2;
   logic [255:0]  dut_in, dut_in2, dut_out, dft_out;
   logic [31:0]   status_in;
   int            testsRun;
   int            testsFailed;

   duft_ap_chain_slave #(.ACCESS_LAT(1), .N_DUT_IN(8), .N_DUT_OUT(8), .N_DFT_OUT(8)) dut (
      .clk(clk), .ap_rst(ap_rst), .addr(addr), .wr_data(wr_data), .rd_wr(rd_wr),
      .ap_start(ap_start), .ap_continue(ap_continue), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .ap_done(ap_done), .ap_return(ap_return), .op_code(op_code), .op_wr(op_wr), .cfg(cfg),
      .dut_in(dut_in), .status_in(status_in), .dut_out(dut_out), .dft_out(dft_out),
      .addr_err(addr_err));

   duft_ap_chain_slave #(.ACCESS_LAT(4), .N_DUT_IN(8), .N_DUT_OUT(8), .N_DFT_OUT(8)) dut4 (
      .clk(clk), .ap_rst(ap_rst2), .addr(addr2), .wr_data(wr_data2), .rd_wr(rd_wr2),
      .ap_start(ap_start2), .ap_continue(ap_continue2), .ap_idle(ap_idle2), .ap_ready(ap_ready2),
      .ap_done(ap_done2), .ap_return(ap_return2), .op_code(op_code2), .op_wr(op_wr2), .cfg(cfg2),
      .dut_in(dut_in2), .status_in(status_in), .dut_out(dut_out), .dft_out(dft_out),
      .addr_err(addr_err2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one transaction on the ACCESS_LAT=1 instance and reports what the handshake did.
   task automatic applyStimulus(input logic rd, input logic [31:0] a, input logic [31:0] d,
                                output int lat, output int rdy, output int idleLow,
                                output int wrP, output int errP, output logic idleAfter);
      lat = 0; rdy = 0; idleLow = 0; wrP = 0; errP = 0;
      addr = a; wr_data = d; rd_wr = rd; ap_start = 1'b1; ap_continue = 1'b0;
      @(posedge clk); #1;
      ap_start = 1'b0; addr = 32'hDEAD_BEEF; wr_data = 32'h0BAD_F00D; rd_wr = ~rd;
      lat = 1;
      while (lat < 50) begin
         rdy += int'(ap_ready); idleLow += int'(!ap_idle);
         wrP += int'(op_wr);    errP += int'(addr_err);
         if (ap_done) break;
         @(posedge clk); #1;
         lat++;
      end
      ap_continue = 1'b1;
      @(posedge clk); #1;
      ap_continue = 1'b0;
      idleAfter = ap_idle;
      rdy += int'(ap_ready); wrP += int'(op_wr); errP += int'(addr_err);
   endtask

   task automatic applyStimulus2(input logic rd, input logic [31:0] a, input logic [31:0] d,
                                 output int lat, output int rdy);
      lat = 0; rdy = 0;
      addr2 = a; wr_data2 = d; rd_wr2 = rd; ap_start2 = 1'b1; ap_continue2 = 1'b0;
      @(posedge clk); #1;
      ap_start2 = 1'b0;
      lat = 1;
      while (lat < 50) begin
         rdy += int'(ap_ready2);
         if (ap_done2) break;
         @(posedge clk); #1;
         lat++;
      end
      ap_continue2 = 1'b1;
      @(posedge clk); #1;
      ap_continue2 = 1'b0;
   endtask

   task automatic test_reset;
      testsRun++;
      if ({ap_idle, ap_ready, ap_done, op_wr, addr_err} !== 5'b10000) begin
         testsFailed++; $display("[TB] FAIL reset_flags: got %b expected 10000", {ap_idle, ap_ready, ap_done, op_wr, addr_err});
      end
      testsRun++;
      if ({ap_return, op_code, cfg} !== 96'h0) begin
         testsFailed++; $display("[TB] FAIL reset_regs: got %h expected 0", {ap_return, op_code, cfg});
      end
      testsRun++;
      if (dut_in !== 256'h0) begin
         testsFailed++; $display("[TB] FAIL reset_dut_in: got %h expected 0", dut_in);
      end
   endtask

   task automatic test_loopback;
      int lat, rdy, idleLow, wrP, errP;
      logic idleAfter;
      applyStimulus(1'b0, 32'hFF00_0000, 32'h0000_7216, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (lat !== 2 || rdy !== 1 || idleLow !== 2 || idleAfter !== 1'b1) begin
         testsFailed++; $display("[TB] FAIL lb_wr_handshake: got lat=%0d rdy=%0d idleLow=%0d idleAfter=%b expected 2 1 2 1", lat, rdy, idleLow, idleAfter);
      end
      applyStimulus(1'b1, 32'hFF00_0001, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (ap_return !== 32'h0000_7216) begin
         testsFailed++; $display("[TB] FAIL lb_read: got %h expected 00007216", ap_return);
      end
      testsRun++;
      if (lat !== 2 || rdy !== 1 || idleLow !== 2 || errP !== 0) begin
         testsFailed++; $display("[TB] FAIL lb_rd_handshake: got lat=%0d rdy=%0d idleLow=%0d err=%0d expected 2 1 2 0", lat, rdy, idleLow, errP);
      end
   endtask

   task automatic test_opcode;
      int lat, rdy, idleLow, wrP, errP;
      logic idleAfter;
      applyStimulus(1'b0, 32'h0, 32'h2, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (op_code !== 32'h2 || wrP !== 1) begin
         testsFailed++; $display("[TB] FAIL opcode_wr2: got op=%h pulses=%0d expected 2 1", op_code, wrP);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (op_code !== 32'h0 || wrP !== 1) begin
         testsFailed++; $display("[TB] FAIL opcode_wr0: got op=%h pulses=%0d expected 0 1", op_code, wrP);
      end
      applyStimulus(1'b1, 32'h0, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (wrP !== 0 || ap_return !== 32'h0) begin
         testsFailed++; $display("[TB] FAIL opcode_rd: got pulses=%0d ret=%h expected 0 0", wrP, ap_return);
      end
   endtask

   task automatic test_windows;
      int lat, rdy, idleLow, wrP, errP;
      logic idleAfter;
      status_in = 32'h0000_0A05;
      dut_out = '0; dut_out[31:0] = 32'h0000_721E; dut_out[255:224] = 32'h0000_7777;
      dft_out = '0; dft_out[127:96] = 32'h1234_5678; dft_out[255:224] = 32'h89AB_CDEF;
      applyStimulus(1'b1, 32'h1, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (ap_return !== 32'h0000_0A05) begin
         testsFailed++; $display("[TB] FAIL rd_state: got %h expected 00000a05", ap_return);
      end
      applyStimulus(1'b1, 32'h18, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (ap_return !== 32'h0000_721E) begin
         testsFailed++; $display("[TB] FAIL rd_dut_out0: got %h expected 0000721e", ap_return);
      end
      applyStimulus(1'b1, 32'h1F, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (ap_return !== 32'h0000_7777) begin
         testsFailed++; $display("[TB] FAIL rd_dut_out7: got %h expected 00007777", ap_return);
      end
      applyStimulus(1'b1, 32'h23, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (ap_return !== 32'h1234_5678) begin
         testsFailed++; $display("[TB] FAIL rd_dft3: got %h expected 12345678", ap_return);
      end
      applyStimulus(1'b1, 32'h27, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (ap_return !== 32'h89AB_CDEF || errP !== 0) begin
         testsFailed++; $display("[TB] FAIL rd_dft7: got %h err=%0d expected 89abcdef 0", ap_return, errP);
      end
      applyStimulus(1'b1, 32'h28, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (ap_return !== 32'h0 || errP !== 1) begin
         testsFailed++; $display("[TB] FAIL rd_dft_beyond: got %h err=%0d expected 0 1", ap_return, errP);
      end
      applyStimulus(1'b0, 32'h12, 32'h0000_CAFE, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (dut_in !== {160'h0, 32'h0000_CAFE, 64'h0}) begin
         testsFailed++; $display("[TB] FAIL wr_dut_in2: got %h expected cafe at [95:64]", dut_in);
      end
      applyStimulus(1'b1, 32'h12, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (ap_return !== 32'h0000_CAFE) begin
         testsFailed++; $display("[TB] FAIL rd_dut_in2: got %h expected 0000cafe", ap_return);
      end
      applyStimulus(1'b0, 32'h2, 32'hA5A5_0001, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (cfg !== 32'hA5A5_0001 || ap_return !== 32'h0000_CAFE || wrP !== 0) begin
         testsFailed++; $display("[TB] FAIL wr_config: got cfg=%h ret=%h opwr=%0d expected a5a50001 0000cafe 0", cfg, ap_return, wrP);
      end
   endtask

   task automatic test_errors;
      int lat, rdy, idleLow, wrP, errP;
      logic idleAfter;
      applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (ap_return !== 32'h0 || errP !== 1 || lat !== 2) begin
         testsFailed++; $display("[TB] FAIL err_rd_invalid: got ret=%h err=%0d lat=%0d expected 0 1 2", ap_return, errP, lat);
      end
      applyStimulus(1'b1, 32'hFF00_0001, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      applyStimulus(1'b0, 32'h18, 32'h1111_2222, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (errP !== 1 || lat !== 2 || ap_return !== 32'h0000_7216 || dut_in !== {160'h0, 32'h0000_CAFE, 64'h0}) begin
         testsFailed++; $display("[TB] FAIL err_wr_dut_out: got err=%0d lat=%0d ret=%h expected 1 2 00007216", errP, lat, ap_return);
      end
      applyStimulus(1'b0, 32'hFF00_0001, 32'h3333_4444, lat, rdy, idleLow, wrP, errP, idleAfter);
      applyStimulus(1'b1, 32'hFF00_0000, 32'h0, lat, rdy, idleLow, wrP, errP, idleAfter);
      testsRun++;
      if (ap_return !== 32'h0000_7216) begin
         testsFailed++; $display("[TB] FAIL err_wr_test_out: got %h expected 00007216", ap_return);
      end
   endtask

   task automatic test_chain_hold;
      int bad;
      int lat;
      bad = 0;
      addr = 32'hFF00_0001; rd_wr = 1'b1; ap_start = 1'b1; ap_continue = 1'b0;
      @(posedge clk); #1;
      ap_start = 1'b0;
      lat = 1;
      while (!ap_done && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      addr = 32'h0000_0001; ap_start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (ap_done !== 1'b1 || ap_return !== 32'h0000_7216 || ap_ready !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      testsRun++;
      if (bad !== 0 || lat !== 2) begin
         testsFailed++; $display("[TB] FAIL chain_hold: got bad=%0d lat=%0d expected 0 2", bad, lat);
      end
      ap_start = 1'b0; ap_continue = 1'b1;
      @(posedge clk); #1;
      ap_continue = 1'b0;
      testsRun++;
      if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_return !== 32'h0000_7216) begin
         testsFailed++; $display("[TB] FAIL chain_release: got idle=%b done=%b ret=%h expected 1 0 00007216", ap_idle, ap_done, ap_return);
      end
   endtask

   task automatic test_reset_mid_op;
      int lat, rdy, doneSeen;
      addr2 = 32'h2; wr_data2 = 32'h55; rd_wr2 = 1'b0; ap_start2 = 1'b1; ap_continue2 = 1'b0;
      @(posedge clk); #1;
      ap_start2 = 1'b0;
      @(posedge clk); #1;
      ap_rst2 = 1'b1;
      @(posedge clk); #1;
      ap_rst2 = 1'b0;
      testsRun++;
      if (ap_idle2 !== 1'b1 || cfg2 !== 32'h0 || ap_done2 !== 1'b0) begin
         testsFailed++; $display("[TB] FAIL rst_mid_op: got idle=%b cfg=%h done=%b expected 1 0 0", ap_idle2, cfg2, ap_done2);
      end
      doneSeen = 0;
      for (int i = 0; i < 6; i++) begin
         doneSeen += int'(ap_done2);
         @(posedge clk); #1;
      end
      testsRun++;
      if (doneSeen !== 0 || cfg2 !== 32'h0) begin
         testsFailed++; $display("[TB] FAIL rst_abandon: got done=%0d cfg=%h expected 0 0", doneSeen, cfg2);
      end
      applyStimulus2(1'b1, 32'h2, 32'h0, lat, rdy);
      testsRun++;
      if (lat !== 5 || rdy !== 1 || ap_return2 !== 32'h0) begin
         testsFailed++; $display("[TB] FAIL lat4_rd_cfg: got lat=%0d rdy=%0d ret=%h expected 5 1 0", lat, rdy, ap_return2);
      end
      applyStimulus2(1'b0, 32'h2, 32'h55, lat, rdy);
      testsRun++;
      if (lat !== 5 || cfg2 !== 32'h55) begin
         testsFailed++; $display("[TB] FAIL lat4_wr_cfg: got lat=%0d cfg=%h expected 5 55", lat, cfg2);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      testsRun = 0; testsFailed = 0;
      ap_rst = 1'b1; ap_rst2 = 1'b1;
      addr = '0; wr_data = '0; rd_wr = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
      addr2 = '0; wr_data2 = '0; rd_wr2 = 1'b0; ap_start2 = 1'b0; ap_continue2 = 1'b0;
      status_in = '0; dut_out = '0; dft_out = '0;
      repeat (3) @(posedge clk);
      #1;
      ap_rst = 1'b0; ap_rst2 = 1'b0;
      test_reset();
      test_loopback();
      test_opcode();
      test_windows();
      test_errors();
      test_chain_hold();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
